// File: rtl/mult_arb_pkg.sv
// Shared constants and types for the shared-multiplier arbiter.
//   DATA_W_DEF   default operand/result width
//   NUM_REQ_MAX  largest supported requester count (tag id is 3 bits)
//   MULT_LAT_DEF default multiplier latency
//   tag_t        {valid, id} carried down the tag pipe alongside the multiplier
package mult_arb_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REQ_MAX  = 8;
  localparam int unsigned MULT_LAT_DEF = 3;
  localparam int unsigned ID_W         = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the eligible vector starting at i_ptr+1 and wrapping; the first
// eligible requester found wins.
//   i_elig   eligible requesters
//   i_ptr    index of the most recently granted requester
//   o_grant  one-hot grant, zero when nobody is eligible
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int N = int'(NUM_REQ);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (!w_found && i_elig[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier between NUM_REQ requesters.
// Round-robin issue of at most one operand pair per cycle; a tag pipe of
// MULT_LAT+1 stages tracks which requester owns each in-flight product and
// routes the result back as a one-cycle pulse MULT_LAT+2 cycles after the
// handshake. Each requester may have one operation outstanding.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_req_valid         per-requester request valid
//   o_req_ready         per-requester accept (one-hot or zero)
//   i_req_dataa/datab   packed operands, slice i belongs to requester i
//   o_resp_valid        one-hot response pulse
//   o_resp_result       low DATA_W bits of the unsigned product
//   o_mult_dataa/datab  registered operands to the multiplier
//   i_mult_result       multiplier output
//   o_busy              any operation outstanding
//   o_grant_count       (MULT_ARB_STATS_EN only) 16-bit saturating handshake
//                       counters, one per requester
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_dataa,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_datab,
  output logic [NUM_REQ-1:0]        o_resp_valid,
  output logic [DATA_W-1:0]         o_resp_result,
  output logic [DATA_W-1:0]         o_mult_dataa,
  output logic [DATA_W-1:0]         o_mult_datab,
  input  logic [DATA_W-1:0]         i_mult_result,
  output logic                      o_busy
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     o_grant_count
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] r_pending;
  logic [PTR_W-1:0]   r_ptr;
  tag_t               r_tag [MULT_LAT+1];
  logic [DATA_W-1:0]  r_mult_dataa;
  logic [DATA_W-1:0]  r_mult_datab;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [DATA_W-1:0]  r_resp_result;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant_raw;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_hs;
  logic [ID_W-1:0]    w_gnt_id;
  logic [DATA_W-1:0]  w_opa;
  logic [DATA_W-1:0]  w_opb;
  logic [NUM_REQ-1:0] w_done;
  tag_t               w_tag_last;

  assign w_elig = i_req_valid & ~r_pending;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_raw)
  );

  // Keep ready low while reset is held so nothing appears accepted.
  assign w_grant = i_reset ? '0 : w_grant_raw;
  // The arbiter only grants valid requesters, so any grant is a handshake.
  assign w_hs    = |w_grant;

  always_comb begin
    w_gnt_id = '0;
    w_opa    = '0;
    w_opb    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_grant[k]) begin
        w_gnt_id = ID_W'(k);
        w_opa    = i_req_dataa[k*DATA_W +: DATA_W];
        w_opb    = i_req_datab[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_tag_last = r_tag[MULT_LAT];

  // Requester whose product is sampled at the end of this cycle.
  always_comb begin
    w_done = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_done[k] = w_tag_last.valid && (w_tag_last.id == ID_W'(k));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pending     <= '0;
      r_ptr         <= PTR_W'(NUM_REQ - 1);
      r_mult_dataa  <= '0;
      r_mult_datab  <= '0;
      r_resp_valid  <= '0;
      r_resp_result <= '0;
      for (int s = 0; s <= int'(MULT_LAT); s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      // Set and clear never hit the same bit: grant needs ~pending, done needs pending.
      r_pending    <= (r_pending | w_grant) & ~w_done;
      r_resp_valid <= w_done;
      if (w_tag_last.valid) begin
        r_resp_result <= i_mult_result;
      end
      if (w_hs) begin
        r_ptr        <= w_gnt_id[PTR_W-1:0];
        r_mult_dataa <= w_opa;
        r_mult_datab <= w_opb;
      end
      r_tag[0] <= '{valid: w_hs, id: w_gnt_id};
      for (int s = 1; s <= int'(MULT_LAT); s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  assign o_req_ready   = w_grant;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_result = r_resp_result;
  assign o_mult_dataa  = r_mult_dataa;
  assign o_mult_datab  = r_mult_datab;
  assign o_busy        = |r_pending;

`ifdef MULT_ARB_STATS_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        r_grant_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (w_grant[k] && (r_grant_cnt[k] != 16'hFFFF)) begin
          r_grant_cnt[k] <= r_grant_cnt[k] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_cnt_out
    assign o_grant_count[g*16 +: 16] = r_grant_cnt[g];
  end
`endif

endmodule
